imm_field_decoder: RTL
======================

Name: imm_field_decoder

Overview:
- ID-stage front end of the RISC-V core.
- Accepts fetched instruction words over a valid/ready handshake and buffers them in a 2-entry skid buffer.
- Slices out the raw immediate fields Imm5, Imm12 and Imm20, plus rs1, rs2 and rd.
- Generates the 2-bit EXTSigned code consumed by the immediate extender, so it is the producer end of the extender's input interface.
- Sits between the IF/ID boundary and the extender/control unit.

Parameters:
- XLEN, 32, instruction and PC width.
- PASS_PC, 1, when 1 the PC is carried through alongside the instruction; when 0, pc_out is tied to 0.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  decoder can accept; registered, equals "skid entry empty".
- inst_in  in  XLEN  instruction word.
- pc_in  in  XLEN  PC of inst_in.
- flush  in  1  discard all buffered instructions (branch/jump redirect).
- out_valid  out  1  decoded fields valid.
- out_ready  in  1  downstream accepts.
- Imm5  out  5  inst[11:7].
- Imm12  out  12  I-type: inst[31:20]; S-type: {inst[31:25], inst[11:7]}; otherwise 0.
- Imm20  out  20  U-type: inst[31:12]; otherwise 0.
- EXTSigned  out  2  `ITYPE_EXT / `STYPE_EXT / `UTYPE_EXT.
- rs1  out  5  inst[19:15].
- rs2  out  5  inst[24:20].
- rd  out  5  inst[11:7].
- no_imm  out  1  instruction uses none of the I/S/U extender formats.
- pc_out  out  XLEN  PC of the presented instruction.

Behaviour:
- Reset (async, rst=1):
  - Both buffer entries invalid; out_valid=0, in_ready=1.
  - All field outputs 0; EXTSigned=`ITYPE_EXT; no_imm=1.
- Buffer states:
  - EMPTY: no entry valid.
  - ONE: output register valid.
  - TWO: output and skid registers valid.
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- State transitions:
  - EMPTY, input transfer -> ONE.
  - ONE, input transfer only -> TWO.
  - ONE, output transfer only -> EMPTY.
  - ONE, both transfers -> ONE; the new word replaces the output register.
  - TWO, output transfer -> ONE; the skid word moves to the output register.
  - in_ready=0 in TWO, so no input is accepted there.
- Latency: 1 cycle from input transfer to out_valid when the buffer was empty. Order is strictly preserved. No bubbles while out_ready=1.
- Fields are decoded combinationally from the output register only. All field outputs hold stable while out_valid=1 and out_ready=0.
- Opcode decode, inst[6:0]:
  - 0010011, 0000011, 1100111, 1110011 -> `ITYPE_EXT, no_imm=0.
  - 0100011 -> `STYPE_EXT, no_imm=0.
  - 0110111, 0010111 -> `UTYPE_EXT, no_imm=0.
  - All others (R, B, J, illegal) -> `ITYPE_EXT with Imm12=0, Imm20=0, no_imm=1.
- EXTSigned never takes an undefined code. The extender's default branch is never exercised.
- Flush:
  - Next cycle the state is EMPTY and out_valid=0, regardless of same-cycle transfers.
  - A word offered in the flush cycle is dropped.
  - A same-cycle output transfer still completes downstream.
- in_ready is 1 in the cycle after a flush.
- Reset asserted mid-stream: immediate return to the reset values; no partial output.
- pc_out follows its instruction through both buffer entries.

Decomposition:
- Shared header ctrl_encode_def.v (existing) holds the following defines:
  - `ITYPE_EXT=2'b00, `STYPE_EXT=2'b01, `UTYPE_EXT=2'b10.
  - Opcode defines `OP_IMM, `OP_LOAD, `OP_JALR, `OP_SYSTEM, `OP_STORE, `OP_LUI, `OP_AUIPC.
- One sub-module: ifid_skid_buf, a generic 2-entry valid/ready skid buffer with flush, width XLEN*2.
- Field slicing and opcode decode stay in imm_field_decoder.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), out_ready=1 -> after 1 cycle: out_valid=1, Imm12=0xFFF, EXTSigned=`ITYPE_EXT, rd=1, rs1=0, no_imm=0.
- sw x2,8(x1) (0x0020A423) -> Imm12=0x008, Imm5=0x08, rs1=1, rs2=2, EXTSigned=`STYPE_EXT.
- lui x5,0x12345 (0x123452B7) -> Imm20=0x12345, rd=5, EXTSigned=`UTYPE_EXT.
- add x3,x1,x2 (0x002081B3) -> no_imm=1, EXTSigned=`ITYPE_EXT, Imm12=0, Imm20=0.
- Backpressure: out_ready=0, push A=0xFFF00093 then B=0x123452B7.
  - in_ready drops to 0 the cycle after B is accepted; the outputs stay on A.
  - Raise out_ready: A is delivered, then B on the next cycle, and in_ready returns to 1.
- Flush and reset:
  - With the buffer in TWO, pulse flush together with in_valid -> next cycle out_valid=0, in_ready=1, and the offered word never appears.
  - Assert rst mid-stream -> out_valid=0 and EXTSigned=`ITYPE_EXT immediately, before the next clock edge.

Source files
------------

// File: rtl/imm_field_decoder_pkg.sv
// Shared encodings for the ID-stage immediate field decoder: extender format
// codes, the opcodes that select them, and the decoded field bundle.
package imm_field_decoder_pkg;

  localparam logic [1:0] ITYPE_EXT = 2'b00;
  localparam logic [1:0] STYPE_EXT = 2'b01;
  localparam logic [1:0] UTYPE_EXT = 2'b10;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [1:0]  ext;
    logic        no_imm;
    logic [11:0] imm12;
    logic [19:0] imm20;
  } imm_dec_t;

  // Formats outside I/S/U fall back to ITYPE_EXT so the extender never sees
  // an undefined code; no_imm tells control to ignore the immediate.
  function automatic imm_dec_t decode_imm(input logic [31:0] inst);
    imm_dec_t d;
    d.ext    = ITYPE_EXT;
    d.no_imm = 1'b1;
    d.imm12  = '0;
    d.imm20  = '0;
    case (inst[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        d.no_imm = 1'b0;
        d.imm12  = inst[31:20];
      end
      OP_STORE: begin
        d.ext    = STYPE_EXT;
        d.no_imm = 1'b0;
        d.imm12  = {inst[31:25], inst[11:7]};
      end
      OP_LUI, OP_AUIPC: begin
        d.ext    = UTYPE_EXT;
        d.no_imm = 1'b0;
        d.imm20  = inst[31:12];
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ifid_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with flush. Output register feeds
// the consumer directly; the skid register absorbs one word under backpressure.
module ifid_skid_buf #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_TWO   = 2'b11;

  logic             out_valid_reg;
  logic             skid_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [WIDTH-1:0] skid_data_reg;
  logic             in_fire;
  logic             out_fire;

  assign in_ready  = ~skid_valid_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid_reg & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      out_data_reg   <= '0;
      skid_data_reg  <= '0;
    end else if (flush) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else begin
      case ({skid_valid_reg, out_valid_reg})
        ST_EMPTY: begin
          if (in_fire) begin
            out_data_reg  <= in_data;
            out_valid_reg <= 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            out_data_reg <= in_data;
          end else if (in_fire) begin
            skid_data_reg  <= in_data;
            skid_valid_reg <= 1'b1;
          end else if (out_fire) begin
            out_valid_reg <= 1'b0;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            out_data_reg   <= skid_data_reg;
            skid_valid_reg <= 1'b0;
          end
        end
        default: begin
          out_valid_reg  <= 1'b0;
          skid_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/imm_field_decoder.sv
// ID-stage front end: buffers fetched {pc, inst} pairs and slices register
// and immediate fields plus the extender format code from the output entry.
module imm_field_decoder
  import imm_field_decoder_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit PASS_PC = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] inst_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      Imm5,
  output logic [11:0]     Imm12,
  output logic [19:0]     Imm20,
  output logic [1:0]      EXTSigned,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            no_imm,
  output logic [XLEN-1:0] pc_out
);

  logic [2*XLEN-1:0] buf_data;
  logic [XLEN-1:0]   inst;
  logic [XLEN-1:0]   pc_buf;
  imm_dec_t          dec;

  ifid_skid_buf #(.WIDTH(2*XLEN)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({pc_in, inst_in}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_data)
  );

  assign inst   = buf_data[XLEN-1:0];
  assign pc_buf = buf_data[2*XLEN-1:XLEN];

  assign dec       = decode_imm(inst[31:0]);
  assign EXTSigned = dec.ext;
  assign no_imm    = dec.no_imm;
  assign Imm12     = dec.imm12;
  assign Imm20     = dec.imm20;
  assign Imm5      = inst[11:7];
  assign rd        = inst[11:7];
  assign rs1       = inst[19:15];
  assign rs2       = inst[24:20];

  // funct3 is consumed by the control unit from its own copy of the word.
  logic unused_funct3;
  assign unused_funct3 = ^inst[14:12];

  generate
    if (PASS_PC) begin : g_pc
      assign pc_out = pc_buf;
    end else begin : g_no_pc
      logic unused_pc;
      assign unused_pc = ^pc_buf;
      assign pc_out    = '0;
    end
  endgenerate

endmodule
